// File: rtl/score_display_ctrl_pkg.sv
// Shared types and helpers for the score display controller.
package score_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    COMMIT
  } state_t;

  localparam logic [6:0] BLANK_SEG = 7'b1111111;

  function automatic logic [31:0] pow10(input int unsigned n);
    logic [31:0] p;
    p = 32'd1;
    for (int unsigned i = 0; i < n; i++) p = p * 32'd10;
    return p;
  endfunction

  // ceil(width/3) nibbles always cover 2^width-1 in decimal (log10(2) < 1/3).
  function automatic int unsigned bcd_nibbles(input int unsigned width);
    return (width + 2) / 3;
  endfunction

endpackage

// File: rtl/score_display_ctrl_if.sv
// Score handshake and display bus between game logic, controller and HEX pins.
interface score_display_ctrl_if #(
  parameter int unsigned WIDTH  = 14,
  parameter int unsigned DIGITS = 4
);
  logic [WIDTH-1:0]    score;
  logic                score_valid;
  logic                score_ready;
  logic                lz_blank;
  logic                blank_all;
  logic [DIGITS*7-1:0] hex;
  logic [DIGITS*4-1:0] digits;
  logic                overflow;
  logic                done;

  modport master (
    output score, score_valid, lz_blank, blank_all,
    input  score_ready, hex, digits, overflow, done
  );

  modport slave (
    input  score, score_valid, lz_blank, blank_all,
    output score_ready, hex, digits, overflow, done
  );
endinterface

// File: rtl/score_display_ctrl_seg7.sv
// BCD digit to active-low seven-segment pattern (bit 6 = g ... bit 0 = a).
module seg7 (
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);
  always_comb begin
    case (bcd_i)
      4'd0:    seg_o = 7'b1000000;
      4'd1:    seg_o = 7'b1111001;
      4'd2:    seg_o = 7'b0100100;
      4'd3:    seg_o = 7'b0110000;
      4'd4:    seg_o = 7'b0011001;
      4'd5:    seg_o = 7'b0010010;
      4'd6:    seg_o = 7'b0000010;
      4'd7:    seg_o = 7'b1111000;
      4'd8:    seg_o = 7'b0000000;
      4'd9:    seg_o = 7'b0010000;
      default: seg_o = 7'bxxxxxxx;
    endcase
  end
endmodule

// File: rtl/score_display_ctrl.sv
// Accepts a binary score, converts it to BCD via double-dabble and drives the
// HEX displays with saturation, leading-zero blanking and global blank.
module score_display_ctrl
  import score_display_pkg::*;
#(
  parameter int unsigned WIDTH  = 14,
  parameter int unsigned DIGITS = 4
) (
  input logic                 clk,
  input logic                 reset_n,
  score_display_ctrl_if.slave bus
);

  localparam int unsigned SNIB  = (bcd_nibbles(WIDTH) > DIGITS) ? bcd_nibbles(WIDTH) : DIGITS;
  localparam int unsigned SW    = SNIB * 4;
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CMP_W = (WIDTH > 32) ? WIDTH : 32;
  localparam logic [CMP_W-1:0] MAX = CMP_W'(pow10(DIGITS) - 32'd1);

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    sh_q, sh_d;
  logic [SW-1:0]       bcd_q, bcd_d, adj;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sat_q, sat_d;
  logic [DIGITS*4-1:0] digits_q, digits_d;
  logic                ovf_q, ovf_d;
  logic                ready, done;
  logic [CMP_W-1:0]    score_ext;
  logic [DIGITS-1:0]   lz_mask;
  logic                zero_run;
  logic [DIGITS*7-1:0] hex_w;

  assign score_ext = CMP_W'(bus.score);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      digits_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      sat_q    <= sat_d;
      digits_q <= digits_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    adj = bcd_q;
    for (int unsigned n = 0; n < SNIB; n++) begin
      if (bcd_q[4*n +: 4] >= 4'd5) adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    sat_d    = sat_q;
    digits_d = digits_q;
    ovf_d    = ovf_q;
    ready    = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.score_valid) begin
          sh_d    = bus.score;
          bcd_d   = '0;
          cnt_d   = CNT_W'(WIDTH - 1);
          sat_d   = (score_ext > MAX);
          state_d = CONV;
        end
      end
      CONV: begin
        {bcd_d, sh_d} = {adj, sh_q} << 1;
        if (cnt_q == '0) state_d = COMMIT;
        else             cnt_d   = cnt_q - 1'b1;
      end
      COMMIT: begin
        digits_d = sat_q ? {DIGITS{4'h9}} : bcd_q[DIGITS*4-1:0];
        ovf_d    = sat_q;
        done     = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan from the most significant digit down; digit 0 is never a candidate.
  always_comb begin
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int unsigned d = DIGITS - 1; d > 0; d--) begin
      zero_run   = zero_run & (digits_q[4*d +: 4] == 4'd0);
      lz_mask[d] = zero_run;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    logic [6:0] seg;
    seg7 u_seg7 (
      .bcd_i (digits_q[4*g +: 4]),
      .seg_o (seg)
    );
    assign hex_w[7*g +: 7] = (bus.blank_all || (bus.lz_blank && lz_mask[g])) ? BLANK_SEG : seg;
  end

  assign bus.score_ready = ready;
  assign bus.done        = done;
  assign bus.digits      = digits_q;
  assign bus.overflow    = ovf_q;
  assign bus.hex         = hex_w;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Scoreboard bench for score_display_ctrl (WIDTH=14, DIGITS=4).
module tb_score_display_ctrl;

  localparam int unsigned WIDTH  = 14;
  localparam int unsigned DIGITS = 4;

  typedef struct packed {
    logic [15:0] dg;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  score_display_ctrl_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  score_display_ctrl #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_ref(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  function automatic exp_t model(input int unsigned s);
    exp_t        e;
    int unsigned v;
    e.dg  = 16'h0;
    e.ovf = 1'b0;
    if (s > 9999) begin
      e.dg  = 16'h9999;
      e.ovf = 1'b1;
    end else begin
      v = s;
      for (int i = 0; i < 4; i++) begin
        e.dg[4*i +: 4] = 4'(v % 10);
        v = v / 10;
      end
    end
    return e;
  endfunction

  function automatic logic [27:0] hex_model(input logic [15:0] dg, input logic lz, input logic ba);
    logic [27:0] h;
    logic        all_zero_above;
    h = '0;
    all_zero_above = 1'b1;
    for (int d = 3; d >= 0; d--) begin
      all_zero_above = all_zero_above && (dg[4*d +: 4] == 4'd0);
      if (ba)                              h[7*d +: 7] = 7'b1111111;
      else if (lz && d > 0 && all_zero_above) h[7*d +: 7] = 7'b1111111;
      else                                 h[7*d +: 7] = seg_ref(dg[4*d +: 4]);
    end
    return h;
  endfunction

  task automatic do_handshake(input logic [13:0] s, input bit hold);
    int cyc;
    bus.score       = s;
    bus.score_valid = 1'b1;
    cyc = 0;
    while (!bus.score_ready && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!bus.score_ready) check("ready_wait", 32'(bus.score_ready), 32'd1);
    sb.push_back(model(s));
    @(posedge clk); #1;
    if (!hold) begin
      bus.score_valid = 1'b0;
      bus.score       = 14'($urandom_range(0, 16383));
    end
  endtask

  // Called at #1 after the handshake edge; returns at #1 after the commit edge.
  task automatic wait_commit(input string tag, input bit scramble, input logic [13:0] next_s);
    int          cyc;
    bit          seen, stable;
    logic [15:0] prev;
    exp_t        e;
    cyc    = 1;
    seen   = 0;
    stable = 1;
    prev   = bus.digits;
    while (!seen && cyc <= 40) begin
      @(negedge clk);
      if (bus.digits !== prev) stable = 0;
      if (bus.done) begin
        seen = 1;
        if (scramble) begin
          bus.score = next_s;
          sb.push_back(model(next_s));
        end
      end else begin
        if (scramble) bus.score = 14'($urandom_range(0, 16383));
        @(posedge clk); #1;
        cyc++;
      end
    end
    check({tag, "_latency"}, 32'(cyc), 32'd15);
    check({tag, "_hold"}, 32'(stable), 32'd1);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_digits"}, 32'(bus.digits), 32'(e.dg));
      check({tag, "_overflow"}, 32'(bus.overflow), 32'(e.ovf));
      check({tag, "_hex"}, 32'(bus.hex), 32'(hex_model(e.dg, bus.lz_blank, bus.blank_all)));
    end
    check({tag, "_ready"}, 32'(bus.score_ready), 32'd1);
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
  endtask

  task automatic convert(input logic [13:0] s, input string tag);
    do_handshake(s, 1'b0);
    wait_commit(tag, 1'b0, 14'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_done;
    reset_n         = 1'b0;
    bus.score       = '0;
    bus.score_valid = 1'b0;
    bus.lz_blank    = 1'b1;
    bus.blank_all   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hex", 32'(bus.hex), {4'h0, 7'h7f, 7'h7f, 7'h7f, 7'b1000000});
    check("rst_digits", 32'(bus.digits), 32'h0);
    check("rst_ready", 32'(bus.score_ready), 32'd1);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    bus.lz_blank = 1'b0;
    #1 check("rst_hex_nolz", 32'(bus.hex), {4'h0, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000});
    bus.lz_blank = 1'b1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    convert(14'd1234, "s1234");
    check("s1234_segs", 32'(bus.hex), {4'h0, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});

    convert(14'd10000, "sat");
    check("sat_value", 32'(bus.digits), 32'h9999);
    check("sat_flag", 32'(bus.overflow), 32'd1);

    convert(14'd7, "s7");
    check("s7_lz_hex", 32'(bus.hex), {4'h0, 7'h7f, 7'h7f, 7'h7f, 7'b1111000});

    convert(14'd405, "s405");
    check("s405_lz_hex", 32'(bus.hex), {4'h0, 7'h7f, 7'b0011001, 7'b1000000, 7'b0010010});
    bus.lz_blank = 1'b0;
    #1 check("s405_nolz_hex", 32'(bus.hex), {4'h0, 7'b1000000, 7'b0011001, 7'b1000000, 7'b0010010});
    bus.blank_all = 1'b1;
    #1 check("blank_all_hex", 32'(bus.hex), {4'h0, 7'h7f, 7'h7f, 7'h7f, 7'h7f});
    bus.blank_all = 1'b0;
    bus.lz_blank  = 1'b1;

    // valid stays high across the whole conversion; only 300 then 555 are taken
    do_handshake(14'd300, 1'b1);
    wait_commit("held1", 1'b1, 14'd555);
    @(posedge clk); #1;
    bus.score_valid = 1'b0;
    wait_commit("held2", 1'b0, 14'd0);

    // reset five cycles into a conversion of 9999
    do_handshake(14'd9999, 1'b0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    reset_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_digits", 32'(bus.digits), 32'h0);
    check("midrst_ready", 32'(bus.score_ready), 32'd1);
    check("midrst_hex", 32'(bus.hex), 32'(hex_model(16'h0, 1'b1, 1'b0)));
    seen_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) seen_done = 1;
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) seen_done = 1;
    end
    check("midrst_no_done", 32'(seen_done), 32'd0);
    check("midrst_digits_after", 32'(bus.digits), 32'h0);
    @(posedge clk); #1;

    convert(14'd42, "s42");
    check("s42_value", 32'(bus.digits), 32'h0042);

    for (int i = 0; i < 6; i++) begin
      bus.lz_blank = 1'($urandom_range(0, 1));
      convert(14'($urandom_range(0, 16383)), "rand");
    end
    convert(14'd9999, "max");
    convert(14'd0, "zero");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/score_display_ctrl.md
Name: score_display_ctrl

Overview:
- Sequences the snake game's score onto the HEX seven-segment displays.
- Accepts a binary score through a valid/ready handshake and converts it to BCD with a sequential shift-add-3 (double-dabble) engine.
- Drives one seg7 decoder per digit and adds leading-zero blanking, saturation and a global blank.
- Sits between the game-logic score counter and the board HEX pins.

Parameters:
- WIDTH, 14, bit width of the binary score input.
- DIGITS, 4, number of decimal digits / HEX displays driven.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- score  input  WIDTH  binary score, sampled on handshake.
- score_valid  input  1  score holds a new value.
- score_ready  output  1  block can accept a score (IDLE only).
- lz_blank  input  1  1 = blank leading zeros; digit 0 is never blanked.
- blank_all  input  1  1 = all segments off; has priority over everything.
- hex  output  DIGITS*7  active-low segments; digit d at [7d+6:7d].
- digits  output  DIGITS*4  currently displayed BCD; digit d at [4d+3:4d].
- overflow  output  1  last accepted score exceeded 10^DIGITS-1.
- done  output  1  one-cycle pulse when new digits are committed.

Behaviour:
- Reset (async assert, sync release):
  - FSM = IDLE; digits = 0; overflow = 0; done = 0; score_ready = 1.
  - hex shows "0" on digit 0. Other digits are blank if lz_blank=1, else show "0".
- FSM states and transitions:
  - IDLE: score_ready=1. On score_valid && score_ready, latch score into shift register sh, clear BCD scratch bcd_s, set bit counter cnt=WIDTH-1, go to CONV.
  - CONV: score_ready=0. Each cycle, for every BCD nibble in bcd_s: if nibble >= 5, add 3. Then shift {bcd_s, sh} left by 1. When cnt==0, go to COMMIT; else decrement cnt. Takes exactly WIDTH cycles.
  - COMMIT (1 cycle): digits <= bcd_s, or all 9s if saturating; overflow updated; done=1; go to IDLE.
- Latency: handshake cycle N → done high in cycle N+WIDTH+1, digits valid from cycle N+WIDTH+2. score_ready returns high in that same cycle.
- Saturation:
  - Compare the latched score against the constant MAX = 10^DIGITS-1 (computed in 32 bits) at accept time.
  - If score > MAX: flag sat, commit all digits = 9, overflow=1. Otherwise overflow=0.
  - If MAX >= 2^WIDTH, saturation never triggers.
- BCD scratch width: DIGITS*4 plus enough extra nibbles to hold WIDTH bits without loss. Only the low DIGITS nibbles are committed.
- digits and hex hold their previous value throughout CONV; no flicker or partial values.
- score_valid while not ready is ignored; the producer holds it until accepted. score may change freely outside the handshake cycle.
- Output decode (combinational from registers and inputs):
  - blank_all=1 → every hex digit = 7'b1111111.
  - Else if lz_blank=1: digit d (d>0) is blank when it and every digit above it are 0.
  - Otherwise hex digit = seg7(digits[d]).
  - The seg7 default X is unreachable, since committed digits are always 0-9.
- reset_n asserted mid-CONV: conversion abandoned, reset values apply, no done pulse.

Decomposition:
- Package score_display_pkg:
  - FSM state enum state_t {IDLE, CONV, COMMIT}.
  - Function pow10(n) for MAX.
  - Constant BLANK_SEG = 7'b1111111.
  - Function bcd_nibbles(width) for scratch sizing.
- Reuse existing seg7 module, DIGITS instances via generate. No new sub-module; the double-dabble step stays inline.

Test Plan:
- Reset with lz_blank=1 → hex digit0=7'b1000000, digits1-3=7'b1111111; digits=0; score_ready=1.
- score=1234 accepted → done exactly 15 cycles after handshake; digits=16'h1234; hex3..0=seg7 patterns 1,2,3,4; overflow=0.
- score=10000 (WIDTH=14, DIGITS=4) → digits=16'h9999, overflow=1. Then score=7 → digits=16'h0007, overflow=0; with lz_blank=1 only digit0 lit.
- score=0405 with lz_blank=1 → digit3 blank, digit2 "4", digit1 "0" lit, digit0 "5". Toggle blank_all=1 → all 7'b1111111 in the same cycle.
- score_valid held high during CONV with changing score → only the first value is accepted; second accepted on score_ready; digits unchanged until COMMIT.
- reset_n pulsed low 5 cycles after accepting 9999 → outputs immediately return to reset values, no done pulse; next score=42 converts to 16'h0042.
